// File: rtl/mem_stage_dmem.sv
// mem_stage_dmem
// Data-memory responder for the MEM stage. A load or store request taken from
// the EXE/MEM register is serviced against an internal word-addressed RAM with
// a fixed wait of LATENCY cycles. The pipeline is stalled while the access is
// in flight and load data is presented to the MEM/WB path on completion.
//
// Ports:
//   clk          pipeline clock, all state updates on posedge
//   rst_n        asynchronous active-low reset
//   mm2reg       load request
//   mwmem        store request (wins over mm2reg when both are high)
//   maluout      byte address; word index is maluout[ADDR_W+1:2]
//   mdata_b      store data
//   mem_stall    freezes PC and pipeline registers while high
//   mdout        load data, held until the next load completes
//   mdout_valid  one-cycle pulse in the cycle a load completes
//   err_misalign one-cycle pulse for a request with maluout[1:0] != 0
//   dbg_addr     backdoor word address
//   dbg_data     combinational read of RAM[dbg_addr]
module mem_stage_dmem #(
    parameter int ADDR_W  = 8,
    parameter int LATENCY = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mm2reg,
    input  logic              mwmem,
    input  logic [31:0]       maluout,
    input  logic [31:0]       mdata_b,
    output logic              mem_stall,
    output logic [31:0]       mdout,
    output logic              mdout_valid,
    output logic              err_misalign,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [31:0]       dbg_data
);

    localparam int         DEPTH    = 1 << ADDR_W;
    localparam logic [2:0] CNT_INIT = 3'(LATENCY - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [2:0]          cnt_q, cnt_d;
    logic                is_load_q, is_load_d;
    logic [ADDR_W-1:0]   idx_q, idx_d;
    logic [31:0]         wdata_q, wdata_d;
    logic [31:0]         mdout_q, mdout_d;
    logic [31:0]         ram_q [DEPTH];
    logic                ram_we_s;
    logic                req_s;
    logic                misalign_s;
    logic [ADDR_W-1:0]   idx_s;
    logic                unused_addr_s;

    assign req_s      = mm2reg | mwmem;
    assign misalign_s = (maluout[1:0] != 2'b00);
    assign idx_s      = maluout[ADDR_W+1:2];
    // Upper address bits wrap away by design.
    assign unused_addr_s = ^maluout[31:ADDR_W+2];

    // Next-state, access control and Mealy outputs.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        is_load_d    = is_load_q;
        idx_d        = idx_q;
        wdata_d      = wdata_q;
        mdout_d      = mdout_q;
        ram_we_s     = 1'b0;
        mem_stall    = 1'b0;
        mdout_valid  = 1'b0;
        err_misalign = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // Nothing is accepted while reset is held, so outputs read zero.
                if (rst_n && req_s) begin
                    if (misalign_s) begin
                        err_misalign = 1'b1;
                    end else begin
                        mem_stall = 1'b1;
                        state_d   = ST_BUSY;
                        cnt_d     = CNT_INIT;
                        // A simultaneous load+store is treated as a store.
                        is_load_d = mm2reg & ~mwmem;
                        idx_d     = idx_s;
                        wdata_d   = mdata_b;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_BUSY: begin
                mem_stall = 1'b1;
                if (cnt_q != 3'd0) begin
                    cnt_d = cnt_q - 3'd1;
                end else begin
                    state_d = ST_DONE;
                    if (is_load_q) begin
                        mdout_d = ram_q[idx_q];
                    end else begin
                        ram_we_s = 1'b1;
                    end
                end
            end
            ST_DONE: begin
                // The completed request is still on the inputs here; going
                // straight to IDLE without sampling keeps it from re-firing.
                mdout_valid = is_load_q;
                state_d     = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Control and data registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= 3'd0;
            is_load_q <= 1'b0;
            idx_q     <= '0;
            wdata_q   <= 32'd0;
            mdout_q   <= 32'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            is_load_q <= is_load_d;
            idx_q     <= idx_d;
            wdata_q   <= wdata_d;
            mdout_q   <= mdout_d;
        end
    end

    // RAM write port; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (ram_we_s) begin
            ram_q[idx_q] <= wdata_q;
        end
    end

    assign mdout    = mdout_q;
    assign dbg_data = ram_q[dbg_addr];

endmodule

// File: tb/tb_mem_stage_dmem.sv
module tb_mem_stage_dmem;

    localparam int LAT0 = 2;
    localparam int LAT1 = 1;

    logic        clk;
    logic        rst_n;
    logic        mm2reg_t   [2];
    logic        mwmem_t    [2];
    logic [31:0] maluout_t  [2];
    logic [31:0] mdata_t    [2];
    logic [7:0]  dbg_addr_t [2];
    logic        stall_o    [2];
    logic [31:0] mdout_o    [2];
    logic        valid_o    [2];
    logic        err_o      [2];
    logic [31:0] dbg_o      [2];

    int total_checks = 0;
    int passed_checks = 0;
    int cyc = 0;

    mem_stage_dmem #(.ADDR_W(8), .LATENCY(LAT0)) dut0 (
        .clk(clk), .rst_n(rst_n), .mm2reg(mm2reg_t[0]), .mwmem(mwmem_t[0]),
        .maluout(maluout_t[0]), .mdata_b(mdata_t[0]), .mem_stall(stall_o[0]),
        .mdout(mdout_o[0]), .mdout_valid(valid_o[0]), .err_misalign(err_o[0]),
        .dbg_addr(dbg_addr_t[0]), .dbg_data(dbg_o[0])
    );

    mem_stage_dmem #(.ADDR_W(8), .LATENCY(LAT1)) dut1 (
        .clk(clk), .rst_n(rst_n), .mm2reg(mm2reg_t[1]), .mwmem(mwmem_t[1]),
        .maluout(maluout_t[1]), .mdata_b(mdata_t[1]), .mem_stall(stall_o[1]),
        .mdout(mdout_o[1]), .mdout_valid(valid_o[1]), .err_misalign(err_o[1]),
        .dbg_addr(dbg_addr_t[1]), .dbg_data(dbg_o[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int lat(input int i);
        return (i == 0) ? LAT0 : LAT1;
    endfunction

    // Values the RAMs are preloaded with.
    function automatic logic [31:0] init_val(input int i, input int w);
        if (i == 0 && w == 2) return 32'h0000_0011;
        return 32'hC0DE_0000 | 32'(w);
    endfunction

    // ---------------- behavioural model ----------------
    // occ = cycles of occupancy still to come after the current cycle;
    // the final one of them is the completion cycle.
    int          occ    [2];
    logic        ld_m   [2];
    logic [7:0]  idx_m  [2];
    logic [31:0] dat_m  [2];
    logic [31:0] mdout_m[2];
    logic [31:0] mem_m  [2][256];
    logic        wr_m   [2][256];

    initial begin
        for (int i = 0; i < 2; i++) begin
            occ[i] = 0;
            mdout_m[i] = 32'd0;
            for (int w = 0; w < 256; w++) wr_m[i][w] = 1'b0;
        end
    end

    function automatic logic [31:0] mem_rd(input int i, input int w);
        return wr_m[i][w] ? mem_m[i][w] : init_val(i, w);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
                occ[i]     <= 0;
                mdout_m[i] <= 32'd0;
            end else if (occ[i] == 0) begin
                if ((mm2reg_t[i] | mwmem_t[i]) && maluout_t[i][1:0] == 2'b00) begin
                    occ[i]   <= lat(i) + 1;
                    ld_m[i]  <= mm2reg_t[i] & ~mwmem_t[i];
                    idx_m[i] <= 8'((maluout_t[i] >> 2) % 256);
                    dat_m[i] <= mdata_t[i];
                end
            end else begin
                if (occ[i] == 2) begin
                    if (ld_m[i]) mdout_m[i] <= mem_rd(i, int'(idx_m[i]));
                    else begin
                        mem_m[i][idx_m[i]] <= dat_m[i];
                        wr_m[i][idx_m[i]]  <= 1'b1;
                    end
                end
                occ[i] <= occ[i] - 1;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_checks++;
        if (act === exp) passed_checks++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Cycle-by-cycle compare against the model.
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            logic req, al, es, ee, ev;
            req = mm2reg_t[i] | mwmem_t[i];
            al  = (maluout_t[i][1:0] == 2'b00);
            if (occ[i] == 0) begin
                es = rst_n & req & al;
                ee = rst_n & req & ~al;
                ev = 1'b0;
            end else begin
                es = (occ[i] > 1);
                ee = 1'b0;
                ev = (occ[i] == 1) && ld_m[i];
            end
            chk($sformatf("stall%0d", i), 32'(stall_o[i]), 32'(es));
            chk($sformatf("err%0d", i), 32'(err_o[i]), 32'(ee));
            chk($sformatf("valid%0d", i), 32'(valid_o[i]), 32'(ev));
            chk($sformatf("mdout%0d", i), mdout_o[i], mdout_m[i]);
            chk($sformatf("dbg%0d", i), dbg_o[i], mem_rd(i, int'(dbg_addr_t[i])));
        end
    end

    // ---------------- stimulus ----------------
    task automatic idle(input int i);
        mm2reg_t[i] = 1'b0; mwmem_t[i] = 1'b0; maluout_t[i] = 32'd0; mdata_t[i] = 32'd0;
    endtask

    // Holds a request for as long as the pipeline would (through completion),
    // and reports what was observed while it was held.
    task automatic do_access(input int i, input logic ld, input logic st,
                             input logic [31:0] addr, input logic [31:0] data,
                             output int stalls, output int valids, output int errs,
                             output int vcyc);
        int n;
        n = (addr[1:0] != 2'b00) ? 1 : lat(i) + 2;
        mm2reg_t[i] = ld; mwmem_t[i] = st; maluout_t[i] = addr; mdata_t[i] = data;
        stalls = 0; valids = 0; errs = 0; vcyc = -1;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            if (stall_o[i]) stalls++;
            if (err_o[i]) errs++;
            if (valid_o[i]) begin valids++; vcyc = cyc; end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        int s, v, e, c, c1;
        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin idle(i); dbg_addr_t[i] = 8'd0; end
        for (int w = 0; w < 256; w++) begin
            dut0.ram_q[w] <= init_val(0, w);
            dut1.ram_q[w] <= init_val(1, w);
        end
        @(negedge clk);
        chk("rst_stall", 32'(stall_o[0]), 32'd0);
        chk("rst_mdout", mdout_o[0], 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Store then load.
        dbg_addr_t[0] = 8'd4;
        do_access(0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, s, v, e, c);
        chk("st_stalls", 32'(s), 32'd3);
        chk("st_valids", 32'(v), 32'd0);
        idle(0);
        chk("st_dbg", dbg_o[0], 32'hDEADBEEF);
        do_access(0, 1'b1, 1'b0, 32'h10, 32'h0, s, v, e, c);
        chk("ld_stalls", 32'(s), 32'd3);
        chk("ld_valids", 32'(v), 32'd1);
        chk("ld_mdout", mdout_o[0], 32'hDEADBEEF);
        idle(0);
        @(posedge clk); #1;

        // Misaligned load.
        do_access(0, 1'b1, 1'b0, 32'h13, 32'h0, s, v, e, c);
        chk("mis_err", 32'(e), 32'd1);
        chk("mis_stalls", 32'(s), 32'd0);
        chk("mis_mdout", mdout_o[0], 32'hDEADBEEF);
        idle(0);
        @(posedge clk); #1;

        // Load and store together acts as a store.
        dbg_addr_t[0] = 8'd8;
        do_access(0, 1'b1, 1'b1, 32'h20, 32'h12345678, s, v, e, c);
        chk("both_valids", 32'(v), 32'd0);
        idle(0);
        chk("both_dbg", dbg_o[0], 32'h12345678);

        // Address wrap.
        dbg_addr_t[0] = 8'd0;
        do_access(0, 1'b0, 1'b1, 32'h400, 32'hA5A5A5A5, s, v, e, c);
        idle(0);
        chk("wrap_dbg", dbg_o[0], 32'hA5A5A5A5);
        do_access(0, 1'b1, 1'b0, 32'h0, 32'h0, s, v, e, c);
        chk("wrap_mdout", mdout_o[0], 32'hA5A5A5A5);
        idle(0);
        @(posedge clk); #1;

        // Reset in cycle 1 of a store.
        dbg_addr_t[0] = 8'd2;
        mwmem_t[0] = 1'b1; maluout_t[0] = 32'h8; mdata_t[0] = 32'h55;
        @(posedge clk); #2;
        rst_n = 1'b0;
        idle(0);
        @(negedge clk);
        chk("mrst_stall", 32'(stall_o[0]), 32'd0);
        chk("mrst_mdout", mdout_o[0], 32'd0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); @(negedge clk);
        chk("mrst_ram", dbg_o[0], 32'h11);
        @(posedge clk); #1;
        do_access(0, 1'b1, 1'b0, 32'h8, 32'h0, s, v, e, c);
        chk("mrst_after_valids", 32'(v), 32'd1);
        chk("mrst_after_mdout", mdout_o[0], 32'h11);
        idle(0);
        @(posedge clk); #1;

        // Back-to-back loads at LATENCY=1.
        do_access(1, 1'b1, 1'b0, 32'h30, 32'h0, s, v, e, c1);
        chk("b2b_first", mdout_o[1], 32'hC0DE000C);
        do_access(1, 1'b1, 1'b0, 32'h34, 32'h0, s, v, e, c);
        chk("b2b_second", mdout_o[1], 32'hC0DE000D);
        chk("b2b_gap", 32'(c - c1), 32'd3);
        idle(1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        $display("%0d/%0d checks passed", passed_checks, total_checks);
        $finish;
    end

endmodule
